// File: rtl/core_ctrl_pkg.sv
// Shared types and defaults for the core run controller.
package core_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RESET_HOLD,
      RUN,
      DONE
   } run_state_t;

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_IMEM_DEPTH   = 64;
   localparam int DEF_RESET_CYCLES = 2;
   localparam int DEF_CNT_WIDTH    = 16;

   // Word-address width for an instruction memory of 'depth' words.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/core_run_controller_if.sv
// Host/core-facing signal bundle of the run controller.
// master = host side (drives control, program stream and halt),
// slave  = controller side (drives memory writes and core control).
interface core_run_controller_if #(
   parameter int DATA_WIDTH = core_ctrl_pkg::DEF_DATA_WIDTH,
   parameter int IMEM_DEPTH = core_ctrl_pkg::DEF_IMEM_DEPTH,
   parameter int CNT_WIDTH  = core_ctrl_pkg::DEF_CNT_WIDTH
);
   import core_ctrl_pkg::*;

   localparam int AW = addr_width(IMEM_DEPTH);

   logic                  start;
   logic                  abort;
   logic [CNT_WIDTH-1:0]  run_limit;
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_last;
   logic                  load_ready;
   logic                  imem_we;
   logic [AW-1:0]         imem_addr;
   logic [DATA_WIDTH-1:0] imem_wdata;
   logic                  halt;
   logic                  core_rst;
   logic                  core_enable;
   logic                  done;
   logic                  timeout;
   logic [CNT_WIDTH-1:0]  cycle_count;

   modport master (
      output start, abort, run_limit, load_valid, load_data, load_last, halt,
      input  load_ready, imem_we, imem_addr, imem_wdata,
             core_rst, core_enable, done, timeout, cycle_count
   );

   modport slave (
      input  start, abort, run_limit, load_valid, load_data, load_last, halt,
      output load_ready, imem_we, imem_addr, imem_wdata,
             core_rst, core_enable, done, timeout, cycle_count
   );

endinterface

// File: rtl/run_cycle_counter.sv
// Saturating up-counter with synchronous load and a "next value hits limit"
// flag. A limit of zero never hits.
module run_cycle_counter import core_ctrl_pkg::*; #(
   parameter int WIDTH = DEF_CNT_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             inc_i,
   input  logic [WIDTH-1:0] limit_i,
   output logic [WIDTH-1:0] cnt_nxt_o,
   output logic             hit_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   assign cnt_nxt_o = (&cnt_q) ? cnt_q : cnt_q + WIDTH'(1);
   assign hit_o     = (limit_i != '0) && (cnt_nxt_o == limit_i);

   // Load wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)     cnt_d = load_val_i;
      else if (inc_i) cnt_d = cnt_nxt_o;
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/core_run_controller.sv
// Run controller: streams a program into instruction memory, holds the core
// in reset for RESET_CYCLES, then runs it until halt or the cycle budget.
module core_run_controller import core_ctrl_pkg::*; #(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int IMEM_DEPTH   = DEF_IMEM_DEPTH,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   core_run_controller_if.slave bus
);

   localparam int                   AW        = addr_width(IMEM_DEPTH);
   localparam logic [AW-1:0]        LAST_ADDR = AW'(IMEM_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LEN  = CNT_WIDTH'(RESET_CYCLES);

   run_state_t            state_q;
   logic [AW-1:0]         ptr_q;
   logic [CNT_WIDTH-1:0]  limit_q;
   logic                  load_ready_q;
   logic                  imem_we_q;
   logic [AW-1:0]         imem_addr_q;
   logic [DATA_WIDTH-1:0] imem_wdata_q;
   logic                  core_rst_q;
   logic                  core_enable_q;
   logic                  done_q;
   logic                  timeout_q;
   logic [CNT_WIDTH-1:0]  cycle_count_q;

   logic                  accept;
   logic                  load_end;
   logic                  cnt_load;
   logic                  cnt_inc;
   logic [CNT_WIDTH-1:0]  cnt_limit;
   logic [CNT_WIDTH-1:0]  cnt_nxt;
   logic                  cnt_hit;

   // load_ready_q is high exactly while loading, so this is the handshake.
   assign accept   = load_ready_q && bus.load_valid;
   // The word landing in the last slot closes the load even without load_last.
   assign load_end = accept && (bus.load_last || (ptr_q == LAST_ADDR));

   // One counter serves two jobs: the reset-hold length, then the run budget.
   // It is zeroed when the load ends and again when the hold completes.
   always_comb begin
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
      cnt_limit = limit_q;
      case (state_q)
         LOAD: cnt_load = load_end;
         RESET_HOLD: begin
            cnt_limit = HOLD_LEN;
            cnt_inc   = 1'b1;
            cnt_load  = cnt_hit;
         end
         RUN:     cnt_inc = 1'b1;
         default: ;
      endcase
   end

   run_cycle_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
      .clk_i      (clk),
      .rst_ni     (rst),
      .load_i     (cnt_load),
      .load_val_i ('0),
      .inc_i      (cnt_inc),
      .limit_i    (cnt_limit),
      .cnt_nxt_o  (cnt_nxt),
      .hit_o      (cnt_hit)
   );

   // Sequencer with registered outputs; abort overrides every state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         limit_q       <= '0;
         load_ready_q  <= 1'b0;
         imem_we_q     <= 1'b0;
         imem_addr_q   <= '0;
         imem_wdata_q  <= '0;
         core_rst_q    <= 1'b0;
         core_enable_q <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         imem_we_q <= 1'b0;
         if (bus.abort) begin
            // cycle_count is deliberately kept for post-mortem reading.
            state_q       <= IDLE;
            load_ready_q  <= 1'b0;
            core_rst_q    <= 1'b0;
            core_enable_q <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
         end else begin
            case (state_q)
               IDLE, DONE: begin
                  if (bus.start) begin
                     state_q       <= LOAD;
                     limit_q       <= bus.run_limit;
                     ptr_q         <= '0;
                     load_ready_q  <= 1'b1;
                     core_rst_q    <= 1'b0;
                     core_enable_q <= 1'b0;
                     done_q        <= 1'b0;
                     timeout_q     <= 1'b0;
                     cycle_count_q <= '0;
                  end
               end
               LOAD: begin
                  if (accept) begin
                     imem_we_q    <= 1'b1;
                     imem_addr_q  <= ptr_q;
                     imem_wdata_q <= bus.load_data;
                     ptr_q        <= ptr_q + AW'(1);
                     if (load_end) begin
                        state_q      <= RESET_HOLD;
                        load_ready_q <= 1'b0;
                     end
                  end
               end
               RESET_HOLD: begin
                  if (cnt_hit) begin
                     state_q       <= RUN;
                     core_rst_q    <= 1'b1;
                     core_enable_q <= 1'b1;
                  end
               end
               RUN: begin
                  cycle_count_q <= cnt_nxt;
                  // Halt wins over a coincident budget hit.
                  if (bus.halt || cnt_hit) begin
                     state_q       <= DONE;
                     core_enable_q <= 1'b0;
                     done_q        <= 1'b1;
                     timeout_q     <= !bus.halt;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.load_ready  = load_ready_q;
   assign bus.imem_we     = imem_we_q;
   assign bus.imem_addr   = imem_addr_q;
   assign bus.imem_wdata  = imem_wdata_q;
   assign bus.core_rst    = core_rst_q;
   assign bus.core_enable = core_enable_q;
   assign bus.done        = done_q;
   assign bus.timeout     = timeout_q;
   assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_core_run_controller;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int RC    = 2;
   localparam int CW    = 8;
   localparam int AW    = 2;
   localparam int MAXC  = (1 << CW) - 1;

   localparam int PH_IDLE = 0, PH_LOAD = 1, PH_HOLD = 2, PH_RUN = 3, PH_DONE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   core_run_controller_if #(.DATA_WIDTH(DW), .IMEM_DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

   core_run_controller #(
      .DATA_WIDTH(DW), .IMEM_DEPTH(DEPTH), .RESET_CYCLES(RC), .CNT_WIDTH(CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   logic [DW-1:0]    prog [6] = '{32'h00500093, 32'h00A00113, 32'h002081B3,
                                  32'h00000073, 32'hDEADBEEF, 32'h12345678};
   logic [AW+DW-1:0] wlog [$];

   // Behavioural model: phase, remaining hold cycles, words taken, run count.
   int            m_ph    = PH_IDLE;
   int            m_hold  = 0;
   int            m_ptr   = 0;
   int            m_cnt   = 0;
   int            m_lim   = 0;
   bit            m_done  = 1'b0;
   bit            m_to    = 1'b0;
   bit            m_we    = 1'b0;
   int            m_addr  = 0;
   logic [DW-1:0] m_data  = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_ph = PH_IDLE; m_done = 0; m_to = 0; m_we = 0; m_cnt = 0; m_ptr = 0;
      end else begin
         m_we = 0;
         if (bus.abort) begin
            m_ph = PH_IDLE; m_done = 0; m_to = 0;
         end else if (m_ph == PH_IDLE || m_ph == PH_DONE) begin
            if (bus.start) begin
               m_ph = PH_LOAD; m_lim = int'(bus.run_limit);
               m_done = 0; m_to = 0; m_cnt = 0; m_ptr = 0;
            end
         end else if (m_ph == PH_LOAD) begin
            if (bus.load_valid) begin
               m_we = 1; m_addr = m_ptr; m_data = bus.load_data; m_ptr++;
               if (bus.load_last || m_ptr == DEPTH) begin
                  m_ph = PH_HOLD; m_hold = RC;
               end
            end
         end else if (m_ph == PH_HOLD) begin
            m_hold--;
            if (m_hold == 0) m_ph = PH_RUN;
         end else begin
            if (m_cnt < MAXC) m_cnt++;
            if (bus.halt) begin
               m_ph = PH_DONE; m_done = 1; m_to = 0;
            end else if (m_lim != 0 && m_cnt == m_lim) begin
               m_ph = PH_DONE; m_done = 1; m_to = 1;
            end
         end
      end
   end

   // Compare process: outputs against the model every falling edge.
   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         chk("load_ready", bus.load_ready, 64'(m_ph == PH_LOAD));
         chk("core_rst", bus.core_rst, 64'(m_ph == PH_RUN || m_ph == PH_DONE));
         chk("core_enable", bus.core_enable, 64'(m_ph == PH_RUN));
         chk("done", bus.done, 64'(m_done));
         chk("cycle_count", bus.cycle_count, 64'(m_cnt));
         chk("imem_we", bus.imem_we, 64'(m_we));
         if (m_we) begin
            chk("imem_addr", bus.imem_addr, 64'(m_addr));
            chk("imem_wdata", bus.imem_wdata, 64'(m_data));
         end
         if (m_done) chk("timeout", bus.timeout, 64'(m_to));
         if (bus.imem_we === 1'b1) wlog.push_back({bus.imem_addr, bus.imem_wdata});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic begin_run(input int lim);
      bus.run_limit = CW'(lim);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic load_words(input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = prog[i];
         bus.load_last  = with_last && (i == n - 1);
         step();
      end
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
   endtask

   task automatic wait_enable(output int n);
      n = 0;
      while (bus.core_enable !== 1'b1 && n < 20) begin n++; step(); end
   endtask

   task automatic run_until_done(output int n);
      n = 0;
      while (bus.core_enable === 1'b1 && n < 400) begin n++; step(); end
   endtask

   task automatic chk_reset_vals();
      chk("rst_load_ready", bus.load_ready, 0);
      chk("rst_imem_we", bus.imem_we, 0);
      chk("rst_imem_addr", bus.imem_addr, 0);
      chk("rst_imem_wdata", bus.imem_wdata, 0);
      chk("rst_core_rst", bus.core_rst, 0);
      chk("rst_core_enable", bus.core_enable, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_timeout", bus.timeout, 0);
      chk("rst_cycle_count", bus.cycle_count, 0);
   endtask

   initial begin
      int n;
      bus.start = 0; bus.abort = 0; bus.run_limit = '0; bus.load_valid = 0;
      bus.load_data = '0; bus.load_last = 0; bus.halt = 0;
      #3 rst = 1'b0;
      #1 chk_reset_vals();
      @(posedge clk); #2 rst = 1'b1;
      chk_on = 1'b1;
      step();

      // Four-word program, budget 16, no halt.
      wlog.delete();
      begin_run(16);
      chk("t1_ready", bus.load_ready, 1);
      load_words(4, 1'b1);
      chk("t1_ready_drop", bus.load_ready, 0);
      chk("t1_core_rst_hold", bus.core_rst, 0);
      wait_enable(n);
      chk("t1_hold_cycles", n, RC);
      run_until_done(n);
      chk("t1_run_cycles", n, 16);
      chk("t1_done", bus.done, 1);
      chk("t1_timeout", bus.timeout, 1);
      chk("t1_count", bus.cycle_count, 16);
      chk("t1_wlen", wlog.size(), 4);
      for (int i = 0; i < 4 && i < wlog.size(); i++) begin
         chk("t1_waddr", wlog[i][AW+DW-1:DW], i);
         chk("t1_wdata", wlog[i][DW-1:0], prog[i]);
      end

      // Unlimited, halt in RUN cycle 5.
      begin_run(0);
      load_words(1, 1'b1);
      wait_enable(n);
      repeat (4) step();
      bus.halt = 1'b1; step(); bus.halt = 1'b0;
      chk("t2_done", bus.done, 1);
      chk("t2_timeout", bus.timeout, 0);
      chk("t2_count", bus.cycle_count, 5);
      chk("t2_enable", bus.core_enable, 0);
      chk("t2_core_rst", bus.core_rst, 1);

      // Halt coincides with limit 8.
      begin_run(8);
      load_words(2, 1'b1);
      wait_enable(n);
      repeat (7) step();
      bus.halt = 1'b1; step(); bus.halt = 1'b0;
      chk("t3_done", bus.done, 1);
      chk("t3_timeout", bus.timeout, 0);
      chk("t3_count", bus.cycle_count, 8);

      // Six words without last into a 4-deep memory.
      wlog.delete();
      begin_run(3);
      for (int i = 0; i < 6; i++) begin
         bus.load_valid = 1'b1; bus.load_data = prog[i]; bus.load_last = 1'b0;
         step();
         if (i == 2) chk("t4_ready_mid", bus.load_ready, 1);
         if (i == 3) chk("t4_ready_drop", bus.load_ready, 0);
         if (i == 4) chk("t4_hold", bus.core_enable, 0);
         if (i == 5) chk("t4_run", bus.core_enable, 1);
      end
      bus.load_valid = 1'b0;
      run_until_done(n);
      chk("t4_run_cycles", n, 3);
      chk("t4_timeout", bus.timeout, 1);
      chk("t4_wlen", wlog.size(), 4);
      for (int i = 0; i < 4 && i < wlog.size(); i++) begin
         chk("t4_waddr", wlog[i][AW+DW-1:DW], i);
         chk("t4_wdata", wlog[i][DW-1:0], prog[i]);
      end

      // Abort in RUN cycle 4, then async reset mid-load, then reload.
      begin_run(0);
      load_words(1, 1'b1);
      wait_enable(n);
      repeat (3) step();
      bus.abort = 1'b1; step(); bus.abort = 1'b0;
      chk("t5_core_rst", bus.core_rst, 0);
      chk("t5_enable", bus.core_enable, 0);
      chk("t5_done", bus.done, 0);
      chk("t5_ready", bus.load_ready, 0);
      chk("t5_count_kept", bus.cycle_count, 3);
      begin_run(0);
      load_words(2, 1'b0);
      bus.load_valid = 1'b1;
      #1 rst = 1'b0;
      #1 chk_reset_vals();
      bus.load_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      wlog.delete();
      begin_run(0);
      chk("t5_count_clr", bus.cycle_count, 0);
      load_words(2, 1'b1);
      step();
      chk("t5_wlen", wlog.size(), 2);
      if (wlog.size() > 0) begin
         chk("t5_waddr0", wlog[0][AW+DW-1:DW], 0);
         chk("t5_wdata0", wlog[0][DW-1:0], prog[0]);
      end
      wait_enable(n);
      bus.halt = 1'b1; step(); bus.halt = 1'b0;

      // Counter saturates at all-ones with no budget.
      begin_run(0);
      load_words(1, 1'b1);
      wait_enable(n);
      repeat (260) step();
      bus.halt = 1'b1; step(); bus.halt = 1'b0;
      chk("t6_sat_count", bus.cycle_count, MAXC);
      chk("t6_timeout", bus.timeout, 0);

      // Randomized traffic, checked by the compare process.
      for (int c = 0; c < 3000; c++) begin
         bus.start      = ($urandom_range(99) < 6);
         bus.abort      = ($urandom_range(199) == 0);
         bus.run_limit  = CW'($urandom_range(25));
         bus.load_valid = ($urandom_range(99) < 60);
         bus.load_data  = $urandom;
         bus.load_last  = ($urandom_range(99) < 30);
         bus.halt       = ($urandom_range(99) < 4);
         if ($urandom_range(499) == 0) begin
            #1 rst = 1'b0;
            #1 rst = 1'b1;
         end
         step();
      end
      bus.start = 0; bus.abort = 0; bus.load_valid = 0; bus.load_last = 0; bus.halt = 0;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
